// File: rtl/variable_assignment_table.sv
// One-bit-per-variable assignment store with two registered read ports, a
// forwarded read-modify-write flip port and a zero/one/LFSR init sweep engine.
module variable_assignment_table #(
  parameter int VARIABLE_ADDRESS_WIDTH = 11,
  parameter int FLIP_COUNT_WIDTH       = 32,
  parameter int LFSR_WIDTH             = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              init_start,
  input  logic [1:0]                        init_mode,
  input  logic [LFSR_WIDTH-1:0]             init_seed,
  output logic                              busy,
  output logic                              ready,
  input  logic                              rd_en_a,
  input  logic [VARIABLE_ADDRESS_WIDTH-1:0] rd_addr_a,
  output logic                              rd_data_a,
  output logic                              rd_valid_a,
  input  logic                              rd_en_b,
  input  logic [VARIABLE_ADDRESS_WIDTH-1:0] rd_addr_b,
  output logic                              rd_data_b,
  output logic                              rd_valid_b,
  input  logic                              flip_en,
  input  logic [VARIABLE_ADDRESS_WIDTH-1:0] flip_addr,
  output logic                              flip_old,
  output logic                              flip_old_valid,
  output logic [FLIP_COUNT_WIDTH-1:0]       flip_count
);

  localparam int DEPTH = 2 ** VARIABLE_ADDRESS_WIDTH;
  localparam logic [VARIABLE_ADDRESS_WIDTH-1:0] LAST_ADDR = {VARIABLE_ADDRESS_WIDTH{1'b1}};
  localparam logic [LFSR_WIDTH-1:0] LFSR_MASK = LFSR_WIDTH'(16'hB400);
  localparam logic [FLIP_COUNT_WIDTH-1:0] COUNT_MAX = {FLIP_COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] v);
    if (v[0]) begin
      lfsr_next = (v >> 1) ^ LFSR_MASK;
    end else begin
      lfsr_next = v >> 1;
    end
  endfunction

  logic                              mem [DEPTH];
  state_t                            state_r, state_s;
  logic [VARIABLE_ADDRESS_WIDTH-1:0] sweep_addr_r;
  logic [LFSR_WIDTH-1:0]             lfsr_r;
  logic [1:0]                        mode_r;
  logic                              wb_valid_r, wb_data_r;
  logic [VARIABLE_ADDRESS_WIDTH-1:0] wb_addr_r;
  logic                              busy_r, ready_r;
  logic                              rd_data_a_r, rd_valid_a_r, rd_data_b_r, rd_valid_b_r;
  logic                              flip_old_r, flip_old_valid_r;
  logic [FLIP_COUNT_WIDTH-1:0]       flip_count_r;
  logic                              start_s, accept_flip_s, sweep_bit_s;
  logic                              fwd_a_s, fwd_b_s, fwd_flip_s;

  // A write-back still in flight is forwarded to every read path.
  assign fwd_a_s    = (wb_valid_r && wb_addr_r == rd_addr_a) ? wb_data_r : mem[rd_addr_a];
  assign fwd_b_s    = (wb_valid_r && wb_addr_r == rd_addr_b) ? wb_data_r : mem[rd_addr_b];
  assign fwd_flip_s = (wb_valid_r && wb_addr_r == flip_addr) ? wb_data_r : mem[flip_addr];

  assign start_s       = init_start && (state_r != ST_SWEEP);
  assign accept_flip_s = flip_en && ready_r;

  // Next-state decode and sweep fill value.
  always_comb begin
    state_s     = state_r;
    sweep_bit_s = 1'b0;
    case (state_r)
      ST_IDLE:  state_s = init_start ? ST_SWEEP : ST_IDLE;
      ST_SWEEP: state_s = (sweep_addr_r == LAST_ADDR) ? ST_RUN : ST_SWEEP;
      ST_RUN:   state_s = init_start ? ST_SWEEP : ST_RUN;
      default:  state_s = ST_IDLE;
    endcase
    case (mode_r)
      2'd1:    sweep_bit_s = 1'b1;
      2'd2:    sweep_bit_s = lfsr_r[0];
      default: sweep_bit_s = 1'b0;
    endcase
  end

  // Table storage; the sweep owns the write port and supersedes any write-back.
  always_ff @(posedge clk) begin
    if (state_r == ST_SWEEP) begin
      mem[sweep_addr_r] <= sweep_bit_s;
    end else if (wb_valid_r) begin
      mem[wb_addr_r] <= wb_data_r;
    end
  end

  // State register, sweep engine and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      ready_r      <= 1'b0;
      sweep_addr_r <= '0;
      lfsr_r       <= LFSR_WIDTH'(1);
      mode_r       <= 2'd0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_SWEEP);
      ready_r <= (state_s == ST_RUN);
      if (start_s) begin
        mode_r       <= init_mode;
        lfsr_r       <= (init_seed == '0) ? LFSR_WIDTH'(1) : init_seed;
        sweep_addr_r <= '0;
      end else if (state_r == ST_SWEEP) begin
        lfsr_r       <= lfsr_next(lfsr_r);
        sweep_addr_r <= sweep_addr_r + VARIABLE_ADDRESS_WIDTH'(1);
      end
    end
  end

  // Read ports, flip pipeline and saturating flip counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a_r      <= 1'b0;
      rd_valid_a_r     <= 1'b0;
      rd_data_b_r      <= 1'b0;
      rd_valid_b_r     <= 1'b0;
      wb_valid_r       <= 1'b0;
      wb_addr_r        <= '0;
      wb_data_r        <= 1'b0;
      flip_old_r       <= 1'b0;
      flip_old_valid_r <= 1'b0;
      flip_count_r     <= '0;
    end else begin
      rd_valid_a_r     <= rd_en_a && ready_r;
      rd_valid_b_r     <= rd_en_b && ready_r;
      wb_valid_r       <= accept_flip_s;
      wb_addr_r        <= flip_addr;
      wb_data_r        <= ~fwd_flip_s;
      flip_old_valid_r <= accept_flip_s;
      if (rd_en_a && ready_r) begin
        rd_data_a_r <= fwd_a_s;
      end
      if (rd_en_b && ready_r) begin
        rd_data_b_r <= fwd_b_s;
      end
      if (accept_flip_s) begin
        flip_old_r <= fwd_flip_s;
      end
      if (start_s) begin
        flip_count_r <= '0;
      end else if (accept_flip_s && flip_count_r != COUNT_MAX) begin
        flip_count_r <= flip_count_r + FLIP_COUNT_WIDTH'(1);
      end
    end
  end

  assign busy           = busy_r;
  assign ready          = ready_r;
  assign rd_data_a      = rd_data_a_r;
  assign rd_valid_a     = rd_valid_a_r;
  assign rd_data_b      = rd_data_b_r;
  assign rd_valid_b     = rd_valid_b_r;
  assign flip_old       = flip_old_r;
  assign flip_old_valid = flip_old_valid_r;
  assign flip_count     = flip_count_r;

endmodule

// File: tb/tb_variable_assignment_table.sv
// Directed self-checking bench for variable_assignment_table on a 16-entry
// table with a 2-bit flip counter.
module tb_variable_assignment_table;

  localparam int AW = 4;
  localparam int FW = 2;
  localparam int LW = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_start;
  logic [1:0]    init_mode;
  logic [LW-1:0] init_seed;
  logic          busy, ready;
  logic          rd_en_a, rd_en_b;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic          rd_data_a, rd_data_b, rd_valid_a, rd_valid_b;
  logic          flip_en;
  logic [AW-1:0] flip_addr;
  logic          flip_old, flip_old_valid;
  logic [FW-1:0] flip_count;

  int checks = 0;
  int errors = 0;

  variable_assignment_table #(
    .VARIABLE_ADDRESS_WIDTH(AW),
    .FLIP_COUNT_WIDTH(FW),
    .LFSR_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .init_start(init_start), .init_mode(init_mode), .init_seed(init_seed),
    .busy(busy), .ready(ready),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .flip_en(flip_en), .flip_addr(flip_addr),
    .flip_old(flip_old), .flip_old_valid(flip_old_valid), .flip_count(flip_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DEPTH-1:0] ref_table(input logic [LW-1:0] seed);
    logic [LW-1:0] s;
    s = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int k = 0; k < DEPTH; k++) begin
      ref_table[k] = s[0];
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
  endfunction

  // Pulse init_start, then wait exactly the sweep length and check the handoff.
  task automatic do_init(input logic [1:0] mode, input logic [LW-1:0] seed);
    init_start = 1'b1; init_mode = mode; init_seed = seed;
    tick();
    init_start = 1'b0;
    check_val("busy_at_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < DEPTH; i++) tick();
    check_val("ready_after_sweep", {30'd0, busy, ready}, 32'd1);
  endtask

  task automatic read_all(output logic [DEPTH-1:0] tbl);
    for (int k = 0; k < DEPTH; k++) begin
      rd_en_a = 1'b1; rd_addr_a = AW'(k);
      tick();
      tbl[k] = rd_data_a;
    end
    rd_en_a = 1'b0;
  endtask

  logic [DEPTH-1:0] tbl, tbl1;

  initial begin
    rst = 1'b1; init_start = 1'b0; init_mode = 2'd0; init_seed = '0;
    rd_en_a = 1'b0; rd_en_b = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    flip_en = 1'b0; flip_addr = '0;
    tick(); tick();
    check_val("reset_state",
              {24'd0, busy, ready, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, flip_old, flip_old_valid},
              32'd0);
    check_val("reset_count", {30'd0, flip_count}, 32'd0);
    rst = 1'b0;
    tick();

    // All-one init with busy-window checks, both ports sweeping opposite ends.
    init_start = 1'b1; init_mode = 2'd1;
    tick();
    init_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check_val($sformatf("sweep_busy_%0d", i), {30'd0, busy, ready}, 32'd2);
      tick();
    end
    check_val("sweep_done", {30'd0, busy, ready}, 32'd1);
    check_val("count_after_init", {30'd0, flip_count}, 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      rd_en_a = 1'b1; rd_addr_a = AW'(k);
      rd_en_b = 1'b1; rd_addr_b = AW'(DEPTH - 1 - k);
      tick();
      check_val($sformatf("ones_a_%0d", k), {30'd0, rd_valid_a, rd_data_a}, 32'd3);
      check_val($sformatf("ones_b_%0d", k), {30'd0, rd_valid_b, rd_data_b}, 32'd3);
    end
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    tick();
    check_val("rd_valid_drop", {30'd0, rd_valid_a, rd_data_a}, 32'd1);

    // LFSR init, and the zero-seed substitution.
    do_init(2'd2, 16'hACE1);
    read_all(tbl);
    check_val("lfsr_ace1", {16'd0, tbl}, {16'd0, ref_table(16'hACE1)});
    do_init(2'd2, 16'h0001);
    read_all(tbl1);
    do_init(2'd2, 16'h0000);
    read_all(tbl);
    check_val("lfsr_seed1", {16'd0, tbl1}, {16'd0, ref_table(16'h0001)});
    check_val("lfsr_seed0", {16'd0, tbl}, {16'd0, tbl1});

    // Flip with read-first on A at t and forwarded read on B at t+1 (mode 3 = zero).
    do_init(2'd3, 16'h1234);
    flip_en = 1'b1; flip_addr = 4'd3; rd_en_a = 1'b1; rd_addr_a = 4'd3;
    tick();
    flip_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b1; rd_addr_b = 4'd3;
    check_val("flip3_old", {30'd0, flip_old_valid, flip_old}, 32'd2);
    check_val("flip3_read_first", {30'd0, rd_valid_a, rd_data_a}, 32'd2);
    check_val("flip3_count", {30'd0, flip_count}, 32'd1);
    tick();
    check_val("flip3_forward", {30'd0, rd_valid_b, rd_data_b}, 32'd3);
    rd_en_a = 1'b1; rd_addr_a = 4'd3;
    tick();
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    check_val("flip3_same_addr", {30'd0, rd_data_a, rd_data_b}, 32'd3);

    // Back-to-back flips of 7, then saturation.
    do_init(2'd0, 16'h0000);
    flip_en = 1'b1; flip_addr = 4'd7;
    tick();
    check_val("flip7_first", {30'd0, flip_old_valid, flip_old}, 32'd2);
    tick();
    flip_en = 1'b0;
    check_val("flip7_second", {30'd0, flip_old_valid, flip_old}, 32'd3);
    rd_en_a = 1'b1; rd_addr_a = 4'd7; rd_en_b = 1'b1; rd_addr_b = 4'd7;
    tick();
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    check_val("flip7_net", {30'd0, rd_data_a, rd_data_b}, 32'd0);
    check_val("flip7_count", {30'd0, flip_count}, 32'd2);
    flip_en = 1'b1; flip_addr = 4'd9;
    tick(); tick(); tick();
    flip_en = 1'b0;
    check_val("count_saturate", {30'd0, flip_count}, 32'd3);

    // Reads and flips during a sweep are ignored.
    init_start = 1'b1; init_mode = 2'd1;
    tick();
    init_start = 1'b0;
    flip_en = 1'b1; flip_addr = 4'd2; rd_en_a = 1'b1; rd_en_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val($sformatf("busy_ignore_%0d", i),
                {29'd0, rd_valid_a, rd_valid_b, flip_old_valid}, 32'd0);
    end
    flip_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check_val("busy_ignore_ready", {31'd0, ready}, 32'd1);
    check_val("busy_ignore_count", {30'd0, flip_count}, 32'd0);
    read_all(tbl);
    check_val("busy_ignore_table", {16'd0, tbl}, 32'h0000FFFF);

    // Reset in the middle of a sweep.
    init_start = 1'b1; init_mode = 2'd0;
    tick();
    init_start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    #1;
    check_val("midsweep_reset", {29'd0, busy, ready, flip_old_valid}, 32'd0);
    check_val("midsweep_count", {30'd0, flip_count}, 32'd0);
    tick();
    rst = 1'b0;
    rd_en_a = 1'b1; flip_en = 1'b1; flip_addr = 4'd1;
    for (int i = 0; i < 20; i++) tick();
    check_val("post_reset_idle", {28'd0, busy, ready, rd_valid_a, flip_old_valid}, 32'd0);
    rd_en_a = 1'b0; flip_en = 1'b0;
    do_init(2'd1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
